// File: rtl/seq_subtractor_if.sv
// Start/done handshake bundle between the controlling FSM and the
// chunked subtractor.
interface seq_subtractor_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [WIDTH-1:0] min_i;
    logic [WIDTH-1:0] sub_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] diff_o;
    logic             borrow_o;

    modport master (
        output start_i,
        output min_i,
        output sub_i,
        input  busy_o,
        input  done_o,
        input  diff_o,
        input  borrow_o
    );

    modport slave (
        input  start_i,
        input  min_i,
        input  sub_i,
        output busy_o,
        output done_o,
        output diff_o,
        output borrow_o
    );
endinterface

// File: rtl/seq_subtractor.sv
// Multi-cycle unsigned subtractor: CHUNK bits per cycle, LSB chunk
// first, with a registered borrow between chunks.
module seq_subtractor #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic           clk_i,
    input logic           rst_i,
    seq_subtractor_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CALC = 1'b1;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic [CHUNK:0]   step;
    int               base;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        diff_d   = diff_q;
        bout_d   = bout_q;

        base = int'(cnt_q) * CHUNK;
        // Extra top bit of the difference is the chunk's borrow out
        step = {1'b0, a_q[base +: CHUNK]}
             - {1'b0, b_q[base +: CHUNK]}
             - {{CHUNK{1'b0}}, borrow_q};

        if (state_q == S_IDLE) begin
            if (bus.start_i) begin
                a_d      = bus.min_i;
                b_d      = bus.sub_i;
                borrow_d = 1'b0;
                cnt_d    = '0;
                busy_d   = 1'b1;
                state_d  = S_CALC;
            end
        end else begin
            work_d[base +: CHUNK] = step[CHUNK-1:0];
            borrow_d = step[CHUNK];
            if (cnt_q == LAST) begin
                diff_d  = work_d;
                bout_d  = step[CHUNK];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.diff_o   = diff_q;
    assign bus.borrow_o = bout_q;
endmodule

// File: tb/tb_seq_subtractor.sv
// Directed bench for seq_subtractor at CHUNK=8, CHUNK=32 and CHUNK=1.
module tb_seq_subtractor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] min_r = '0;
    logic [31:0] sub_r = '0;
    int          sel = 0;
    int          n_tot = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    seq_subtractor_if #(.WIDTH(32)) if8 ();
    seq_subtractor_if #(.WIDTH(32)) if32 ();
    seq_subtractor_if #(.WIDTH(32)) if1 ();

    assign if8.start_i  = start && (sel == 0);
    assign if32.start_i = start && (sel == 1);
    assign if1.start_i  = start && (sel == 2);
    assign if8.min_i    = min_r;
    assign if8.sub_i    = sub_r;
    assign if32.min_i   = min_r;
    assign if32.sub_i   = sub_r;
    assign if1.min_i    = min_r;
    assign if1.sub_i    = sub_r;

    seq_subtractor #(.WIDTH(32), .CHUNK(8)) u8 (
        .clk_i(clk), .rst_i(rst), .bus(if8)
    );
    seq_subtractor #(.WIDTH(32), .CHUNK(32)) u32 (
        .clk_i(clk), .rst_i(rst), .bus(if32)
    );
    seq_subtractor #(.WIDTH(32), .CHUNK(1)) u1 (
        .clk_i(clk), .rst_i(rst), .bus(if1)
    );

    logic        busy_m;
    logic        done_m;
    logic        borrow_m;
    logic [31:0] diff_m;

    always_comb begin
        busy_m   = if8.busy_o;
        done_m   = if8.done_o;
        borrow_m = if8.borrow_o;
        diff_m   = if8.diff_o;
        case (sel)
            1: begin
                busy_m   = if32.busy_o;
                done_m   = if32.done_o;
                borrow_m = if32.borrow_o;
                diff_m   = if32.diff_o;
            end
            2: begin
                busy_m   = if1.busy_o;
                done_m   = if1.done_o;
                borrow_m = if1.borrow_o;
                diff_m   = if1.diff_o;
            end
            default: ;
        endcase
    end

    // Drives one request and returns edges from acceptance to done
    // (-1 if done never came) and the number of busy cycles seen.
    task automatic run_op(input int s, input logic [31:0] a,
                          input logic [31:0] b,
                          output int lat, output int bcnt);
        sel = s;
        @(negedge clk);
        min_r = a;
        sub_r = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        bcnt = busy_m ? 1 : 0;
        lat = -1;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            if (done_m) begin
                lat = k;
                break;
            end
            if (busy_m) bcnt++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tot++;
        if (if8.busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy got=%b exp=0", if8.busy_o);
        end
        n_tot++;
        if (if8.done_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_done got=%b exp=0", if8.done_o);
        end
        n_tot++;
        if (if8.diff_o !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_diff got=%h exp=0", if8.diff_o);
        end
        n_tot++;
        if (if8.borrow_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_borrow got=%b exp=0", if8.borrow_o);
        end
        n_tot++;
        if ({if32.busy_o, if1.busy_o, if32.diff_o, if1.diff_o} !== 66'h0) begin
            n_bad++;
            $display("FAIL reset_sweep_duts got=%h/%h exp=0",
                     if32.diff_o, if1.diff_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat, bc;
        run_op(0, 32'h5, 32'h3, lat, bc);
        n_tot++;
        if (lat !== 4) begin
            n_bad++;
            $display("FAIL basic_latency got=%0d exp=4", lat);
        end
        n_tot++;
        if (bc !== 4) begin
            n_bad++;
            $display("FAIL basic_busy_cycles got=%0d exp=4", bc);
        end
        n_tot++;
        if (diff_m !== 32'h2) begin
            n_bad++;
            $display("FAIL basic_diff got=%h exp=00000002", diff_m);
        end
        n_tot++;
        if (borrow_m !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_borrow got=%b exp=0", borrow_m);
        end
        @(posedge clk);
        #1;
        n_tot++;
        if (done_m !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_done_pulse got=%b exp=0", done_m);
        end
        n_tot++;
        if (diff_m !== 32'h2) begin
            n_bad++;
            $display("FAIL basic_diff_hold got=%h exp=00000002", diff_m);
        end
    endtask

    task automatic test_borrow;
        int lat, bc;
        run_op(0, 32'h0, 32'h1, lat, bc);
        n_tot++;
        if (diff_m !== 32'hFFFF_FFFF || borrow_m !== 1'b1) begin
            n_bad++;
            $display("FAIL ripple got=%h/%b exp=ffffffff/1", diff_m, borrow_m);
        end
        run_op(0, 32'h100, 32'h1, lat, bc);
        n_tot++;
        if (diff_m !== 32'h0000_00FF || borrow_m !== 1'b0) begin
            n_bad++;
            $display("FAIL cross_chunk got=%h/%b exp=000000ff/0", diff_m, borrow_m);
        end
        run_op(0, 32'h1234_5678, 32'h1234_5678, lat, bc);
        n_tot++;
        if (diff_m !== 32'h0 || borrow_m !== 1'b0) begin
            n_bad++;
            $display("FAIL equal_ops got=%h/%b exp=00000000/0", diff_m, borrow_m);
        end
    endtask

    task automatic test_handshake;
        int lat, bc, lat2;
        sel = 0;
        @(negedge clk);
        min_r = 32'h9;
        sub_r = 32'h4;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        bc = busy_m ? 1 : 0;
        lat = -1;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) start = 1'b0;
            if (done_m) begin
                lat = k;
                break;
            end
            if (busy_m) bc++;
            if (k == 1) begin
                min_r = 32'h7;
                sub_r = 32'h7;
                start = 1'b1;
            end
        end
        n_tot++;
        if (lat !== 4 || bc !== 4) begin
            n_bad++;
            $display("FAIL busy_ignore_timing got=%0d/%0d exp=4/4", lat, bc);
        end
        n_tot++;
        if (diff_m !== 32'h5 || borrow_m !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_ignore_result got=%h/%b exp=00000005/0", diff_m, borrow_m);
        end
        min_r = 32'h10;
        sub_r = 32'h20;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_tot++;
        if (busy_m !== 1'b1 || done_m !== 1'b0) begin
            n_bad++;
            $display("FAIL done_cycle_accept got=%b/%b exp=1/0", busy_m, done_m);
        end
        lat2 = -1;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            if (done_m) begin
                lat2 = k;
                break;
            end
            if (k == 3) begin
                n_tot++;
                if (diff_m !== 32'h5) begin
                    n_bad++;
                    $display("FAIL diff_hold_busy got=%h exp=00000005", diff_m);
                end
            end
        end
        n_tot++;
        if (lat2 !== 4) begin
            n_bad++;
            $display("FAIL back_to_back_latency got=%0d exp=4", lat2);
        end
        n_tot++;
        if (diff_m !== 32'hFFFF_FFF0 || borrow_m !== 1'b1) begin
            n_bad++;
            $display("FAIL back_to_back_result got=%h/%b exp=fffffff0/1", diff_m, borrow_m);
        end
    endtask

    task automatic test_reset_midop;
        int lat, bc;
        logic seen;
        run_op(0, 32'h3, 32'h1, lat, bc);
        n_tot++;
        if (diff_m !== 32'h2) begin
            n_bad++;
            $display("FAIL pre_reset_diff got=%h exp=00000002", diff_m);
        end
        @(negedge clk);
        min_r = 32'h0000_FFFF;
        sub_r = 32'h1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_tot++;
        if (diff_m !== 32'h0 || borrow_m !== 1'b0) begin
            n_bad++;
            $display("FAIL midop_reset_outputs got=%h/%b exp=00000000/0", diff_m, borrow_m);
        end
        n_tot++;
        if (busy_m !== 1'b0 || done_m !== 1'b0) begin
            n_bad++;
            $display("FAIL midop_reset_busy got=%b/%b exp=0/0", busy_m, done_m);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            seen = seen | done_m;
        end
        n_tot++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL midop_no_done got=%b exp=0", seen);
        end
        run_op(0, 32'h20, 32'h1, lat, bc);
        n_tot++;
        if (lat !== 4 || diff_m !== 32'h1F || borrow_m !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_op got=%0d/%h/%b exp=4/0000001f/0", lat, diff_m, borrow_m);
        end
    endtask

    task automatic test_sweep;
        int lat, bc;
        run_op(1, 32'h8000_0000, 32'h1, lat, bc);
        n_tot++;
        if (lat !== 1 || bc !== 1) begin
            n_bad++;
            $display("FAIL chunk32_latency got=%0d/%0d exp=1/1", lat, bc);
        end
        n_tot++;
        if (diff_m !== 32'h7FFF_FFFF || borrow_m !== 1'b0) begin
            n_bad++;
            $display("FAIL chunk32_result got=%h/%b exp=7fffffff/0", diff_m, borrow_m);
        end
        run_op(2, 32'h8000_0000, 32'h1, lat, bc);
        n_tot++;
        if (lat !== 32 || bc !== 32) begin
            n_bad++;
            $display("FAIL chunk1_latency got=%0d/%0d exp=32/32", lat, bc);
        end
        n_tot++;
        if (diff_m !== 32'h7FFF_FFFF || borrow_m !== 1'b0) begin
            n_bad++;
            $display("FAIL chunk1_result got=%h/%b exp=7fffffff/0", diff_m, borrow_m);
        end
        run_op(2, 32'h0, 32'h1, lat, bc);
        n_tot++;
        if (diff_m !== 32'hFFFF_FFFF || borrow_m !== 1'b1) begin
            n_bad++;
            $display("FAIL chunk1_ripple got=%h/%b exp=ffffffff/1", diff_m, borrow_m);
        end
        run_op(0, 32'h8000_0000, 32'h1, lat, bc);
        n_tot++;
        if (lat !== 4 || diff_m !== 32'h7FFF_FFFF) begin
            n_bad++;
            $display("FAIL chunk8_sweep got=%0d/%h exp=4/7fffffff", lat, diff_m);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_handshake();
        test_reset_midop();
        test_sweep();
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
